mb_boundary_ctx: RTL

- Parametrised successor to the per-macroblock boundary saver in the intra-prediction / reconstruction path.
- Stores the bottom row of each reconstructed MB in an internal top-line RAM, and keeps the right column and top-left corner in registers.
- Serves the full prediction context for the next MB through valid/ready handshakes: top row, top-right extension, left column and top-left, for Y, U and V.
- Adds things the earlier block lacks: frame-start restart, configurable edge values, a configurable top-right extension, an explicit fetch/commit ordering, and out-of-range detection.

---
 rtl/mb_boundary_ctx.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mb_boundary_ctx.sv
// Macroblock boundary context store.
// Keeps the bottom row of every reconstructed MB in a top-line RAM and the
// right column / top-left corner in registers. It serves the prediction
// context (top row + top-right extension, left column, top-left) for one MB
// at a time, then takes that MB's reconstructed boundary back as a store.
module mb_boundary_ctx #(
  parameter int         MB_SIZE   = 16,
  parameter int         MAX_MB_W  = 1024,
  parameter int         TOP_EXT   = 4,
  parameter logic [7:0] EDGE_TOP  = 8'd127,
  parameter logic [7:0] EDGE_LEFT = 8'd129,
  localparam int        C         = MB_SIZE / 2,
  localparam int        AW        = $clog2(MAX_MB_W)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_start,
  input  logic [AW:0]                    cfg_mb_w,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [AW-1:0]                  req_x,
  input  logic [AW-1:0]                  req_y,
  output logic                           ctx_valid,
  input  logic                           ctx_ready,
  output logic [8*(MB_SIZE+TOP_EXT)-1:0] ctx_top_y,
  output logic [8*C-1:0]                 ctx_top_u,
  output logic [8*C-1:0]                 ctx_top_v,
  output logic [8*MB_SIZE-1:0]           ctx_left_y,
  output logic [8*C-1:0]                 ctx_left_u,
  output logic [8*C-1:0]                 ctx_left_v,
  output logic [7:0]                     ctx_tl_y,
  output logic [7:0]                     ctx_tl_u,
  output logic [7:0]                     ctx_tl_v,
  output logic                           ctx_err,
  input  logic                           st_valid,
  output logic                           st_ready,
  input  logic [8*MB_SIZE-1:0]           st_bot_y,
  input  logic [8*C-1:0]                 st_bot_u,
  input  logic [8*C-1:0]                 st_bot_v,
  input  logic [8*MB_SIZE-1:0]           st_right_y,
  input  logic [8*C-1:0]                 st_right_u,
  input  logic [8*C-1:0]                 st_right_v
);

  localparam int          YW   = 8 * MB_SIZE;
  localparam int          CW   = 8 * C;
  localparam int          TW   = 8 * (MB_SIZE + TOP_EXT);
  localparam int          RW   = YW + 2 * CW;   // RAM word: {v, u, y}
  localparam logic [AW:0] MAXW = (AW+1)'(MAX_MB_W);

  typedef enum logic [2:0] {IDLE, RD_CUR, RD_NXT, CTX, WAIT_ST} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] x_q, x_d, y_q, y_d;
  logic [AW:0]   mbw_q, mbw_d;
  logic [RW-1:0] cur_q, cur_d;       // fetched top[x], kept for tl on store
  logic [RW-1:0] ram_rd_q;
  logic [RW-1:0] mem_q [MAX_MB_W];

  logic [YW-1:0] left_y_q, left_y_d;
  logic [CW-1:0] left_u_q, left_u_d, left_v_q, left_v_d;
  logic [7:0]    tl_y_q, tl_y_d, tl_u_q, tl_u_d, tl_v_q, tl_v_d;

  logic [TW-1:0] ctx_top_y_q, ctx_top_y_d, asm_top_y;
  logic [CW-1:0] ctx_top_u_q, ctx_top_u_d, asm_top_u;
  logic [CW-1:0] ctx_top_v_q, ctx_top_v_d, asm_top_v;
  logic [YW-1:0] ctx_left_y_q, ctx_left_y_d, asm_left_y;
  logic [CW-1:0] ctx_left_u_q, ctx_left_u_d, asm_left_u;
  logic [CW-1:0] ctx_left_v_q, ctx_left_v_d, asm_left_v;
  logic [7:0]    ctx_tl_y_q, ctx_tl_y_d, asm_tl_y;
  logic [7:0]    ctx_tl_u_q, ctx_tl_u_d, asm_tl_u;
  logic [7:0]    ctx_tl_v_q, ctx_tl_v_d, asm_tl_v;
  logic          ctx_valid_q, ctx_valid_d, ctx_err_q, ctx_err_d;

  logic [AW:0]   xp1;
  logic          in_range, nxt_ok;
  logic          ram_re, ram_we;
  logic [AW-1:0] ram_addr;
  logic          do_latch, do_asm, ctx_done, do_commit;

  // x+1 is one bit wider so the last RAM column does not wrap to 0
  assign xp1      = {1'b0, x_q} + (AW+1)'(1);
  assign in_range = {1'b0, x_q} < mbw_q;
  assign nxt_ok   = (xp1 < mbw_q) && (xp1 < MAXW);

  assign req_ready = (state_q == IDLE);
  assign st_ready  = (state_q == WAIT_ST);

  // Sequencing: two RAM reads, assemble, hand out context, wait for store
  always_comb begin
    state_d   = state_q;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = x_q;
    do_latch  = 1'b0;
    do_asm    = 1'b0;
    ctx_done  = 1'b0;
    do_commit = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        do_latch = 1'b1;
        state_d  = RD_CUR;
      end
      RD_CUR: begin
        ram_re  = ({1'b0, x_q} < MAXW);
        state_d = RD_NXT;
      end
      RD_NXT: begin
        ram_re   = nxt_ok;
        ram_addr = xp1[AW-1:0];
        state_d  = CTX;
      end
      CTX: begin
        if (!ctx_valid_q) begin
          do_asm = 1'b1;
        end else if (ctx_ready) begin
          ctx_done = 1'b1;
          state_d  = WAIT_ST;
        end
      end
      WAIT_ST: if (st_valid) begin
        do_commit = 1'b1;
        // out-of-range MBs complete the handshake but never touch the RAM
        ram_we    = in_range && ({1'b0, x_q} < MAXW);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (frame_start) begin
      state_d   = IDLE;
      ram_re    = 1'b0;
      ram_we    = 1'b0;
      do_latch  = 1'b0;
      do_asm    = 1'b0;
      ctx_done  = 1'b0;
      do_commit = 1'b0;
    end
  end

  // Context selection: out-of-range, then picture top row, then stored data
  always_comb begin
    asm_top_y  = {(MB_SIZE+TOP_EXT){EDGE_LEFT}};
    asm_top_u  = {C{EDGE_LEFT}};
    asm_top_v  = {C{EDGE_LEFT}};
    asm_left_y = {MB_SIZE{EDGE_LEFT}};
    asm_left_u = {C{EDGE_LEFT}};
    asm_left_v = {C{EDGE_LEFT}};
    asm_tl_y   = EDGE_LEFT;
    asm_tl_u   = EDGE_LEFT;
    asm_tl_v   = EDGE_LEFT;
    if (in_range) begin
      if (y_q == '0) begin
        asm_top_y = {(MB_SIZE+TOP_EXT){EDGE_TOP}};
        asm_top_u = {C{EDGE_TOP}};
        asm_top_v = {C{EDGE_TOP}};
        asm_tl_y  = EDGE_TOP;
        asm_tl_u  = EDGE_TOP;
        asm_tl_v  = EDGE_TOP;
      end else begin
        asm_top_y[YW-1:0] = cur_q[YW-1:0];
        asm_top_u         = cur_q[YW +: CW];
        asm_top_v         = cur_q[YW+CW +: CW];
        // last MB of the row has no right neighbour: replicate its last pixel
        for (int i = 0; i < TOP_EXT; i++)
          asm_top_y[YW+8*i +: 8] = nxt_ok ? ram_rd_q[8*i +: 8] : cur_q[YW-8 +: 8];
        if (x_q != '0) begin
          asm_tl_y = tl_y_q;
          asm_tl_u = tl_u_q;
          asm_tl_v = tl_v_q;
        end
      end
      if (x_q != '0) begin
        asm_left_y = left_y_q;
        asm_left_u = left_u_q;
        asm_left_v = left_v_q;
      end
    end
  end

  // Next-state values of the datapath registers
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    mbw_d        = mbw_q;
    cur_d        = cur_q;
    left_y_d     = left_y_q;
    left_u_d     = left_u_q;
    left_v_d     = left_v_q;
    tl_y_d       = tl_y_q;
    tl_u_d       = tl_u_q;
    tl_v_d       = tl_v_q;
    ctx_top_y_d  = ctx_top_y_q;
    ctx_top_u_d  = ctx_top_u_q;
    ctx_top_v_d  = ctx_top_v_q;
    ctx_left_y_d = ctx_left_y_q;
    ctx_left_u_d = ctx_left_u_q;
    ctx_left_v_d = ctx_left_v_q;
    ctx_tl_y_d   = ctx_tl_y_q;
    ctx_tl_u_d   = ctx_tl_u_q;
    ctx_tl_v_d   = ctx_tl_v_q;
    ctx_valid_d  = ctx_valid_q;
    ctx_err_d    = ctx_err_q;
    if (do_latch) begin
      x_d = req_x;
      y_d = req_y;
    end
    if (state_q == RD_NXT) cur_d = ram_rd_q;
    if (do_asm) begin
      ctx_top_y_d  = asm_top_y;
      ctx_top_u_d  = asm_top_u;
      ctx_top_v_d  = asm_top_v;
      ctx_left_y_d = asm_left_y;
      ctx_left_u_d = asm_left_u;
      ctx_left_v_d = asm_left_v;
      ctx_tl_y_d   = asm_tl_y;
      ctx_tl_u_d   = asm_tl_u;
      ctx_tl_v_d   = asm_tl_v;
      ctx_valid_d  = 1'b1;
      ctx_err_d    = !in_range;
    end
    if (ctx_done) ctx_valid_d = 1'b0;
    if (do_commit) begin
      left_y_d = st_right_y;
      left_u_d = st_right_u;
      left_v_d = st_right_v;
      // top-left of the next MB = bottom-right of the MB above this one
      tl_y_d   = cur_q[YW-8 +: 8];
      tl_u_d   = cur_q[YW+CW-8 +: 8];
      tl_v_d   = cur_q[RW-8 +: 8];
    end
    if (frame_start) begin
      ctx_valid_d = 1'b0;
      mbw_d       = cfg_mb_w;
      left_y_d    = {MB_SIZE{EDGE_LEFT}};
      left_u_d    = {C{EDGE_LEFT}};
      left_v_d    = {C{EDGE_LEFT}};
      tl_y_d      = EDGE_LEFT;
      tl_u_d      = EDGE_LEFT;
      tl_v_d      = EDGE_LEFT;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      mbw_q        <= '0;
      cur_q        <= '0;
      left_y_q     <= {MB_SIZE{EDGE_LEFT}};
      left_u_q     <= {C{EDGE_LEFT}};
      left_v_q     <= {C{EDGE_LEFT}};
      tl_y_q       <= EDGE_LEFT;
      tl_u_q       <= EDGE_LEFT;
      tl_v_q       <= EDGE_LEFT;
      ctx_top_y_q  <= '0;
      ctx_top_u_q  <= '0;
      ctx_top_v_q  <= '0;
      ctx_left_y_q <= '0;
      ctx_left_u_q <= '0;
      ctx_left_v_q <= '0;
      ctx_tl_y_q   <= '0;
      ctx_tl_u_q   <= '0;
      ctx_tl_v_q   <= '0;
      ctx_valid_q  <= 1'b0;
      ctx_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      mbw_q        <= mbw_d;
      cur_q        <= cur_d;
      left_y_q     <= left_y_d;
      left_u_q     <= left_u_d;
      left_v_q     <= left_v_d;
      tl_y_q       <= tl_y_d;
      tl_u_q       <= tl_u_d;
      tl_v_q       <= tl_v_d;
      ctx_top_y_q  <= ctx_top_y_d;
      ctx_top_u_q  <= ctx_top_u_d;
      ctx_top_v_q  <= ctx_top_v_d;
      ctx_left_y_q <= ctx_left_y_d;
      ctx_left_u_q <= ctx_left_u_d;
      ctx_left_v_q <= ctx_left_v_d;
      ctx_tl_y_q   <= ctx_tl_y_d;
      ctx_tl_u_q   <= ctx_tl_u_d;
      ctx_tl_v_q   <= ctx_tl_v_d;
      ctx_valid_q  <= ctx_valid_d;
      ctx_err_q    <= ctx_err_d;
    end
  end

  // Top-line RAM: single port, registered read, never reset
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_addr] <= {st_bot_v, st_bot_u, st_bot_y};
    if (ram_re) ram_rd_q <= mem_q[ram_addr];
  end

  assign ctx_valid  = ctx_valid_q;
  assign ctx_err    = ctx_err_q;
  assign ctx_top_y  = ctx_top_y_q;
  assign ctx_top_u  = ctx_top_u_q;
  assign ctx_top_v  = ctx_top_v_q;
  assign ctx_left_y = ctx_left_y_q;
  assign ctx_left_u = ctx_left_u_q;
  assign ctx_left_v = ctx_left_v_q;
  assign ctx_tl_y   = ctx_tl_y_q;
  assign ctx_tl_u   = ctx_tl_u_q;
  assign ctx_tl_v   = ctx_tl_v_q;

endmodule
